// File: rtl/plic_lite_pkg.sv
// Shared constants for the plic_lite interrupt controller: bus widths,
// register map offsets and ID/priority types.
package plic_pkg;
    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ID_W     = 5;
    localparam int unsigned PRIO_W_D = 3;

    localparam logic [ADDR_W-1:0] PRIO_BASE  = 12'h000;
    localparam logic [ADDR_W-1:0] PEND_OFF   = 12'h080;
    localparam logic [ADDR_W-1:0] EN_OFF     = 12'h100;
    localparam logic [ADDR_W-1:0] THRESH_OFF = 12'h200;
    localparam logic [ADDR_W-1:0] CLAIM_OFF  = 12'h204;

    typedef logic [PRIO_W_D-1:0] prio_t;
    typedef logic [ID_W-1:0]     irq_id_t;
endpackage

// File: rtl/plic_lite_if.sv
// Data-memory bus slice seen by the interrupt controller.
interface plic_lite_if;
    import plic_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, wdata, wr_en, rd_en, input rdata);
    modport slave  (input addr, wdata, wr_en, rd_en, output rdata);
endinterface

// File: rtl/plic_lite_gateway.sv
// Per-source gateway: latches a level request as pending, blocks re-pending
// while the claimed request is in flight.
module irq_gateway (
    input  logic clk,
    input  logic reset,
    input  logic src,
    input  logic claim,
    input  logic complete,
    output logic pending,
    output logic in_flight
);
    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= 1'b0;
            in_flight <= 1'b0;
        end else begin
            // claim only ever targets a pending source, so it never meets a complete
            if (claim) begin
                pending   <= 1'b0;
                in_flight <= 1'b1;
            end else if (src && !pending && !in_flight) begin
                pending <= 1'b1;
            end
            if (complete) begin
                in_flight <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/plic_lite.sv
// Lite platform interrupt controller: register file, gateways, priority
// arbiter and registered external interrupt request.
module plic_lite
    import plic_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned PRIO_W  = PRIO_W_D
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_irq,
    plic_lite_if.slave         bus,
    output logic               ext_irq
);
    logic [PRIO_W-1:0]  prio [NUM_SRC];
    logic [PRIO_W-1:0]  threshold;
    logic [PRIO_W-1:0]  best;
    logic [NUM_SRC-1:0] enable, pending, in_flight;
    logic [NUM_SRC-1:0] claim, complete, prio_sel;
    irq_id_t            winner, cpl_id;
    logic [ADDR_W-1:0]  word_addr;
    logic               claim_hit, cpl_hit, unused_bits;

    assign word_addr   = {bus.addr[ADDR_W-1:2], 2'b00};
    assign claim_hit   = bus.rd_en && (word_addr == CLAIM_OFF);
    assign cpl_hit     = bus.wr_en && (word_addr == CLAIM_OFF);
    assign cpl_id      = bus.wdata[ID_W-1:0];
    assign unused_bits = ^{bus.addr[1:0], bus.wdata};

    // Strict '>' keeps the lowest ID on equal priority.
    always_comb begin
        winner = '0;
        best   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (pending[i] && enable[i] && (prio[i] > threshold) &&
                ((winner == '0) || (prio[i] > best))) begin
                winner = ID_W'(i + 1);
                best   = prio[i];
            end
        end
    end

    always_comb begin
        prio_sel = '0;
        claim    = '0;
        complete = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            prio_sel[i] = (word_addr == PRIO_BASE + ADDR_W'(4 * (i + 1)));
            claim[i]    = claim_hit && (winner == ID_W'(i + 1));
            complete[i] = cpl_hit && (cpl_id == ID_W'(i + 1)) && in_flight[i];
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
        irq_gateway u_gw (
            .clk       (clk),
            .reset     (reset),
            .src       (src_irq[g]),
            .claim     (claim[g]),
            .complete  (complete[g]),
            .pending   (pending[g]),
            .in_flight (in_flight[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                prio[i] <= '0;
            end
            enable    <= '0;
            threshold <= '0;
            ext_irq   <= 1'b0;
        end else begin
            ext_irq <= (winner != '0);
            if (bus.wr_en) begin
                for (int unsigned i = 0; i < NUM_SRC; i++) begin
                    if (prio_sel[i]) begin
                        prio[i] <= bus.wdata[PRIO_W-1:0];
                    end
                end
                if (word_addr == EN_OFF) begin
                    enable <= bus.wdata[NUM_SRC:1];
                end
                if (word_addr == THRESH_OFF) begin
                    threshold <= bus.wdata[PRIO_W-1:0];
                end
            end
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.rd_en && !reset) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (prio_sel[i]) begin
                    bus.rdata = DATA_W'(prio[i]);
                end
            end
            if (word_addr == PEND_OFF)   bus.rdata = DATA_W'({pending, 1'b0});
            if (word_addr == EN_OFF)     bus.rdata = DATA_W'({enable, 1'b0});
            if (word_addr == THRESH_OFF) bus.rdata = DATA_W'(threshold);
            if (word_addr == CLAIM_OFF)  bus.rdata = DATA_W'(winner);
        end
    end
endmodule
